// File: rtl/turbosound_n_pkg.sv
// Shared types and constants for the TurboSound block and its mixer.
//   stereo_mode_t    : panning mode (value 3 is treated as ABC)
//   PORT_AY_SEL_MASK : d[7:3] pattern of a chip-select write to #FFFD
//   AY_MAX_CHIPS     : upper bound on hosted chips
package turbosound_n_pkg;
    typedef enum logic [1:0] {
        ST_ABC  = 2'd0,
        ST_ACB  = 2'd1,
        ST_MONO = 2'd2
    } stereo_mode_t;

    localparam logic [4:0] PORT_AY_SEL_MASK = 5'b11111;
    localparam int         AY_MAX_CHIPS     = 4;
endpackage

// File: rtl/cpu_bus.sv
// Shared CPU bus seen by the sound blocks.
//   ioreq, rd, wr : Z80-style strobes, active high
//   a_reg         : registered address
//   d_reg         : registered write data
interface cpu_bus;
    logic        ioreq;
    logic        rd;
    logic        wr;
    logic [15:0] a_reg;
    logic [7:0]  d_reg;

    modport slave (input ioreq, rd, wr, a_reg, d_reg);
endinterface

// File: rtl/ay_stereo_mix.sv
// Per-chip panning, chained adder over chips, registered stereo output.
//   mode          : panning mode
//   chip_on       : per-chip enable; disabled chips add 0
//   ch_a..ch_c    : per-chip channel levels
//   left, right   : sums, one clk28 after the channel levels
module ay_stereo_mix
    import turbosound_n_pkg::*;
#(
    parameter int NUM_CHIPS = 2,
    parameter int OUT_W     = 11
) (
    input  logic                      clk28,
    input  logic                      rst_n,
    input  stereo_mode_t              mode,
    input  logic [NUM_CHIPS-1:0]      chip_on,
    input  logic [NUM_CHIPS-1:0][7:0] ch_a,
    input  logic [NUM_CHIPS-1:0][7:0] ch_b,
    input  logic [NUM_CHIPS-1:0][7:0] ch_c,
    output logic [OUT_W-1:0]          left,
    output logic [OUT_W-1:0]          right
);
    logic [NUM_CHIPS:0][OUT_W-1:0] acc_l, acc_r;
    logic [OUT_W-1:0] left_q, left_d, right_q, right_d;

    assign acc_l[0] = '0;
    assign acc_r[0] = '0;

    for (genvar i = 0; i < NUM_CHIPS; i++) begin : g_pan
        logic [9:0] a, b, c, l, r;
        assign a = {2'b00, ch_a[i]};
        assign b = {2'b00, ch_b[i]};
        assign c = {2'b00, ch_c[i]};
        always_comb begin
            l = 10'd0;
            r = 10'd0;
            if (chip_on[i]) begin
                case (mode)
                    ST_ACB:  begin l = (a << 1) + c; r = (b << 1) + c; end
                    ST_MONO: begin l = a + b + c;    r = a + b + c;    end
                    default: begin l = (a << 1) + b; r = (c << 1) + b; end
                endcase
            end
        end
        assign acc_l[i+1] = acc_l[i] + OUT_W'(l);
        assign acc_r[i+1] = acc_r[i] + OUT_W'(r);
    end

    assign left_d  = acc_l[NUM_CHIPS];
    assign right_d = acc_r[NUM_CHIPS];
    assign left    = left_q;
    assign right   = right_q;

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            left_q  <= '0;
            right_q <= '0;
        end else begin
            left_q  <= left_d;
            right_q <= right_d;
        end
    end
endmodule

// File: rtl/ym2149.sv
// Behavioural YM2149/AY register file with BDIR/BC1 bus and static channel
// levels: a channel outputs its volume register while its tone-disable bit
// in R7 is set, else 0. Levels refresh on ce.
//   clk28, rst_n : clock, async active-low reset
//   ce           : chip clock enable
//   mode         : 1 = YM readback (full bytes), 0 = AY readback (unused bits 0)
//   bdir, bc1    : bus phase; a8 must be high for the chip to respond
//   di / dout    : data in / selected register readback
//   ch_a..ch_c   : channel levels
module ym2149 (
    input  logic       clk28,
    input  logic       rst_n,
    input  logic       ce,
    input  logic       mode,
    input  logic       bdir,
    input  logic       bc1,
    input  logic       a8,
    input  logic [7:0] di,
    output logic [7:0] dout,
    output logic [7:0] ch_a,
    output logic [7:0] ch_b,
    output logic [7:0] ch_c
);
    logic [7:0] regs_q [16];
    logic [7:0] regs_d [16];
    logic [3:0] addr_q, addr_d;
    logic [7:0] ch_a_q, ch_a_d, ch_b_q, ch_b_d, ch_c_q, ch_c_d;
    logic [7:0] rd_mask;

    always_comb begin
        regs_d = regs_q;
        addr_d = addr_q;
        ch_a_d = ch_a_q;
        ch_b_d = ch_b_q;
        ch_c_d = ch_c_q;
        // address latch only accepts 0..15 (upper nibble is the chip address)
        if (a8 && bdir && bc1 && (di[7:4] == 4'h0)) addr_d = di[3:0];
        if (a8 && bdir && !bc1) regs_d[addr_q] = di;
        if (ce) begin
            ch_a_d = regs_q[7][0] ? regs_q[8]  : 8'h00;
            ch_b_d = regs_q[7][1] ? regs_q[9]  : 8'h00;
            ch_c_d = regs_q[7][2] ? regs_q[10] : 8'h00;
        end
    end

    always_comb begin
        rd_mask = 8'hFF;
        if (!mode) begin
            case (addr_q)
                4'd1, 4'd3, 4'd5, 4'd13: rd_mask = 8'h0F;
                4'd6, 4'd8, 4'd9, 4'd10: rd_mask = 8'h1F;
                default:                 rd_mask = 8'hFF;
            endcase
        end
    end

    assign dout = regs_q[addr_q] & rd_mask;
    assign ch_a = ch_a_q;
    assign ch_b = ch_b_q;
    assign ch_c = ch_c_q;

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) regs_q[i] <= 8'h00;
            addr_q <= 4'd0;
            ch_a_q <= 8'h00;
            ch_b_q <= 8'h00;
            ch_c_q <= 8'h00;
        end else begin
            regs_q <= regs_d;
            addr_q <= addr_d;
            ch_a_q <= ch_a_d;
            ch_b_q <= ch_b_d;
            ch_c_q <= ch_c_d;
        end
    end
endmodule

// File: rtl/turbosound_n.sv
// TurboSound host for NUM_CHIPS YM2149s behind #FFFD/#BFFD, with runtime
// chip select, runtime chip-count limit, AY clock-enable divider and mixer.
//   rst_n, clk28  : async active-low reset, 28 MHz clock
//   ck35          : 3.5 MHz strobe, one clk28 wide
//   en            : port decode enable
//   chips_en      : enabled chip count minus 1 (saturated to NUM_CHIPS-1)
//   stereo_mode   : 0/3 ABC, 1 ACB, 2 mono
//   bus           : CPU bus (ioreq, rd, wr, a_reg, d_reg)
//   d_out         : selected chip readback, 0 when not driving
//   d_out_active  : readback drive request
//   left, right   : mixed outputs
module turbosound_n
    import turbosound_n_pkg::*;
#(
    parameter int  NUM_CHIPS = 2,
    parameter int  CE_DIV    = 2,
    localparam int OUT_W     = 10 + $clog2(NUM_CHIPS)
) (
    input  logic             rst_n,
    input  logic             clk28,
    input  logic             ck35,
    input  logic             en,
    input  logic [1:0]       chips_en,
    input  logic [1:0]       stereo_mode,
    cpu_bus.slave            bus,
    output logic [7:0]       d_out,
    output logic             d_out_active,
    output logic [OUT_W-1:0] left,
    output logic [OUT_W-1:0] right
);
    localparam logic [1:0] MAX_IDX  = 2'(NUM_CHIPS - 1);
    localparam logic [2:0] CNT_LAST = 3'(CE_DIV - 1);

    logic       port_bffd, port_fffd, sel_wr;
    logic [1:0] limit, sel_idx;
    logic [1:0] sel_q, sel_d;
    logic       bc1_q, bc1_d, bdir_q, bdir_d;
    logic [2:0] cnt_q, cnt_d;
    logic       ce_q, ce_d;
    logic       unused_addr;

    logic [7:0]                chip_dout [AY_MAX_CHIPS];
    logic [NUM_CHIPS-1:0][7:0] ch_a, ch_b, ch_c;
    logic [NUM_CHIPS-1:0]      chip_on;

    assign port_bffd   = en & bus.ioreq & bus.a_reg[15] & ~bus.a_reg[1];
    assign port_fffd   = port_bffd & bus.a_reg[14];
    assign limit       = (chips_en > MAX_IDX) ? MAX_IDX : chips_en;
    assign sel_idx     = ~bus.d_reg[1:0];
    assign sel_wr      = port_fffd & bus.wr & (bus.d_reg[7:3] == PORT_AY_SEL_MASK);
    assign unused_addr = ^{bus.a_reg[13:2], bus.a_reg[0]};

    always_comb begin
        sel_d = sel_q;
        // shrinking the chip count beats a same-cycle select write
        if (sel_q > limit)                         sel_d = 2'd0;
        else if (sel_wr && (sel_idx <= limit))     sel_d = sel_idx;
        // a select write must not reach the chips as an address latch
        bc1_d  = port_fffd & ~sel_wr;
        bdir_d = port_bffd & bus.wr & ~sel_wr;
        cnt_d  = cnt_q;
        ce_d   = 1'b0;
        if (ck35) begin
            cnt_d = (cnt_q == CNT_LAST) ? 3'd0 : cnt_q + 3'd1;
            ce_d  = (cnt_q == CNT_LAST);
        end
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            sel_q  <= 2'd0;
            bc1_q  <= 1'b0;
            bdir_q <= 1'b0;
            cnt_q  <= 3'd0;
            ce_q   <= 1'b0;
        end else begin
            sel_q  <= sel_d;
            bc1_q  <= bc1_d;
            bdir_q <= bdir_d;
            cnt_q  <= cnt_d;
            ce_q   <= ce_d;
        end
    end

    assign d_out_active = bus.rd & bc1_q & ~bdir_q;
    assign d_out        = d_out_active ? chip_dout[sel_q] : 8'h00;

    for (genvar i = 0; i < AY_MAX_CHIPS; i++) begin : g_chip
        if (i < NUM_CHIPS) begin : g_on
            logic chip_rst_n;
            assign chip_on[i] = (limit >= 2'(i));
            assign chip_rst_n = rst_n & chip_on[i];
            ym2149 u_ym (
                .clk28 (clk28),
                .rst_n (chip_rst_n),
                .ce    (ce_q),
                .mode  ((i == 0) ? 1'b1 : 1'b0),
                .bdir  (bdir_q),
                .bc1   (bc1_q),
                .a8    (sel_q == 2'(i)),
                .di    (bus.d_reg),
                .dout  (chip_dout[i]),
                .ch_a  (ch_a[i]),
                .ch_b  (ch_b[i]),
                .ch_c  (ch_c[i])
            );
        end else begin : g_off
            assign chip_dout[i] = 8'h00;
        end
    end

    ay_stereo_mix #(.NUM_CHIPS(NUM_CHIPS), .OUT_W(OUT_W)) u_mix (
        .clk28   (clk28),
        .rst_n   (rst_n),
        .mode    (stereo_mode_t'(stereo_mode)),
        .chip_on (chip_on),
        .ch_a    (ch_a),
        .ch_b    (ch_b),
        .ch_c    (ch_c),
        .left    (left),
        .right   (right)
    );
endmodule

// File: tb/tb_turbosound_n.sv
// Bench for turbosound_n: a 4-chip CE_DIV=2 instance is checked in depth,
// a 1-chip CE_DIV=3 instance on the same bus is checked for its ce period.
module tb_turbosound_n;
    logic       clk28 = 1'b0;
    logic       rst_n = 1'b0;
    logic       ck35  = 1'b0;
    logic       en    = 1'b0;
    logic [1:0] chips_en    = 2'd0;
    logic [1:0] stereo_mode = 2'd0;

    cpu_bus bus_if ();

    logic [7:0]  d_out;
    logic        d_out_active;
    logic [11:0] left, right;
    logic [7:0]  unused_b_dout;
    logic        unused_b_act;
    logic [9:0]  unused_b_left, unused_b_right;

    int n_pass  = 0;
    int n_total = 0;

    turbosound_n #(.NUM_CHIPS(4), .CE_DIV(2)) dut (
        .rst_n(rst_n), .clk28(clk28), .ck35(ck35), .en(en),
        .chips_en(chips_en), .stereo_mode(stereo_mode), .bus(bus_if),
        .d_out(d_out), .d_out_active(d_out_active), .left(left), .right(right)
    );

    turbosound_n #(.NUM_CHIPS(1), .CE_DIV(3)) dut_b (
        .rst_n(rst_n), .clk28(clk28), .ck35(ck35), .en(en),
        .chips_en(chips_en), .stereo_mode(stereo_mode), .bus(bus_if),
        .d_out(unused_b_dout), .d_out_active(unused_b_act),
        .left(unused_b_left), .right(unused_b_right)
    );

    initial forever #5 clk28 = ~clk28;

    initial begin
        int k;
        k = 0;
        forever begin
            @(negedge clk28);
            k++;
            ck35 = (k % 8 == 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    typedef struct packed {
        logic        wr_op;
        logic        en_v;
        logic [15:0] a;
        logic [7:0]  d;
        logic [1:0]  cen;
        logic [7:0]  exp_dout;
        logic        exp_act;
        logic [1:0]  exp_sel;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    function automatic logic cur_ce(input bit which);
        return which ? dut_b.ce_q : dut.ce_q;
    endfunction

    task automatic bus_op(input logic wr_op, input logic en_v, input logic [15:0] a,
                          input logic [7:0] d, output logic [7:0] dout_s, output logic act_s);
        @(negedge clk28);
        en = en_v;
        bus_if.a_reg = a;
        bus_if.d_reg = d;
        bus_if.ioreq = 1'b1;
        bus_if.rd    = ~wr_op;
        bus_if.wr    = wr_op;
        @(negedge clk28);
        @(negedge clk28);
        dout_s = d_out;
        act_s  = d_out_active;
        bus_if.ioreq = 1'b0;
        bus_if.rd    = 1'b0;
        bus_if.wr    = 1'b0;
        en = 1'b1;
        @(negedge clk28);
    endtask

    task automatic ay_write(input logic [7:0] r, input logic [7:0] v);
        logic [7:0] dd;
        logic       aa;
        bus_op(1'b1, 1'b1, 16'hFFFD, r, dd, aa);
        bus_op(1'b1, 1'b1, 16'hBFFD, v, dd, aa);
    endtask

    task automatic wait_ce(input bit which, input string nm, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk28);
            if (cur_ce(which)) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_total++;
            $display("FAIL %s: no ce within 64 cycles", nm);
        end
    endtask

    task automatic measure_ce(input bit which, input int exp_p, input string nm);
        bit ok;
        int cyc;
        wait_ce(which, nm, ok);
        if (ok) begin
            @(negedge clk28);
            check({nm, "_width"}, 32'(cur_ce(which)), 0);
            cyc = 1;
            ok  = 1'b0;
            for (int k = 0; k < 64; k++) begin
                @(negedge clk28);
                cyc++;
                if (cur_ce(which)) begin ok = 1'b1; break; end
            end
            if (ok) check({nm, "_period"}, cyc, exp_p);
            else begin
                n_total++;
                $display("FAIL %s_period: no second ce within 64 cycles", nm);
            end
        end
    endtask

    initial begin
        logic [7:0] dd;
        logic       aa;
        bit         ok;

        vecs[0]  = '{1'b1, 1'b1, 16'hFFFD, 8'h07, 2'd3, 8'h00, 1'b0, 2'd0};
        vecs[1]  = '{1'b1, 1'b1, 16'hBFFD, 8'h55, 2'd3, 8'h00, 1'b0, 2'd0};
        vecs[2]  = '{1'b0, 1'b1, 16'hFFFD, 8'h00, 2'd3, 8'h55, 1'b1, 2'd0};
        vecs[3]  = '{1'b0, 1'b0, 16'hFFFD, 8'h00, 2'd3, 8'h00, 1'b0, 2'd0};
        vecs[4]  = '{1'b0, 1'b1, 16'hBFFD, 8'h00, 2'd3, 8'h00, 1'b0, 2'd0};
        vecs[5]  = '{1'b1, 1'b1, 16'hFFFD, 8'hFD, 2'd3, 8'h00, 1'b0, 2'd2};
        vecs[6]  = '{1'b1, 1'b1, 16'hFFFD, 8'h07, 2'd3, 8'h00, 1'b0, 2'd2};
        vecs[7]  = '{1'b1, 1'b1, 16'hBFFD, 8'hAA, 2'd3, 8'h00, 1'b0, 2'd2};
        vecs[8]  = '{1'b0, 1'b1, 16'hFFFD, 8'h00, 2'd3, 8'hAA, 1'b1, 2'd2};
        vecs[9]  = '{1'b1, 1'b1, 16'hFFFF, 8'hFF, 2'd3, 8'h00, 1'b0, 2'd2};
        vecs[10] = '{1'b1, 1'b1, 16'hFFFD, 8'hFF, 2'd3, 8'h00, 1'b0, 2'd0};
        vecs[11] = '{1'b0, 1'b1, 16'hFFFD, 8'h00, 2'd3, 8'h55, 1'b1, 2'd0};
        vecs[12] = '{1'b1, 1'b1, 16'hFFFD, 8'hFC, 2'd1, 8'h00, 1'b0, 2'd0};
        vecs[13] = '{1'b1, 1'b1, 16'hFFFD, 8'hFE, 2'd1, 8'h00, 1'b0, 2'd1};
        vecs[14] = '{1'b1, 1'b1, 16'hFFFD, 8'hFC, 2'd1, 8'h00, 1'b0, 2'd1};
        vecs[15] = '{1'b1, 1'b1, 16'hFFFD, 8'h03, 2'd1, 8'h00, 1'b0, 2'd1};
        vecs[16] = '{1'b1, 1'b1, 16'hBFFD, 8'hFF, 2'd1, 8'h00, 1'b0, 2'd1};
        vecs[17] = '{1'b0, 1'b1, 16'hFFFD, 8'h00, 2'd1, 8'h0F, 1'b1, 2'd1};
        vecs[18] = '{1'b1, 1'b1, 16'h7FFD, 8'hFF, 2'd1, 8'h00, 1'b0, 2'd1};

        bus_if.ioreq = 1'b0;
        bus_if.rd    = 1'b0;
        bus_if.wr    = 1'b0;
        bus_if.a_reg = 16'h0000;
        bus_if.d_reg = 8'h00;
        en = 1'b1;

        repeat (3) @(negedge clk28);
        check("rst_left", 32'(left), 0);
        check("rst_right", 32'(right), 0);
        check("rst_dout", 32'(d_out), 0);
        check("rst_act", 32'(d_out_active), 0);
        check("rst_sel", 32'(dut.sel_q), 0);
        #3 rst_n = 1'b1;

        measure_ce(1'b0, 16, "ce_div2");
        measure_ce(1'b1, 24, "ce_div3");

        // chip0: tones off, A=#FF, B=#20, C=#00
        ay_write(8'h07, 8'hFF);
        ay_write(8'h08, 8'hFF);
        ay_write(8'h0A, 8'h00);
        ay_write(8'h09, 8'h20);
        repeat (40) @(negedge clk28);
        check("mix_abc_b32_l", 32'(left), 542);
        check("mix_abc_b32_r", 32'(right), 32);

        wait_ce(1'b0, "ce_sync", ok);
        bus_op(1'b1, 1'b1, 16'hBFFD, 8'h10, dd, aa);
        wait_ce(1'b0, "ce_after_write", ok);
        if (ok) begin
            @(negedge clk28);
            check("mix_latency_old_l", 32'(left), 542);
            @(negedge clk28);
            check("mix_abc_l", 32'(left), 526);
            check("mix_abc_r", 32'(right), 16);
        end
        stereo_mode = 2'd1;
        @(negedge clk28);
        check("mix_acb_l", 32'(left), 510);
        check("mix_acb_r", 32'(right), 32);
        stereo_mode = 2'd2;
        @(negedge clk28);
        check("mix_mono_l", 32'(left), 271);
        check("mix_mono_r", 32'(right), 271);
        stereo_mode = 2'd3;
        @(negedge clk28);
        check("mix_mode3_l", 32'(left), 526);
        check("mix_mode3_r", 32'(right), 16);

        for (int i = 0; i < NV; i++) begin
            chips_en = vecs[i].cen;
            bus_op(vecs[i].wr_op, vecs[i].en_v, vecs[i].a, vecs[i].d, dd, aa);
            check($sformatf("vec%0d_dout", i), 32'(dd), 32'(vecs[i].exp_dout));
            check($sformatf("vec%0d_act", i), 32'(aa), 32'(vecs[i].exp_act));
            check($sformatf("vec%0d_sel", i), 32'(dut.sel_q), 32'(vecs[i].exp_sel));
            check($sformatf("vec%0d_idle_dout", i), 32'(d_out), 0);
        end

        // shrink chip count below sel: sel drops, chip1 is reset
        @(negedge clk28);
        chips_en = 2'd0;
        @(negedge clk28);
        check("shrink_sel", 32'(dut.sel_q), 0);
        chips_en = 2'd1;
        bus_op(1'b1, 1'b1, 16'hFFFD, 8'hFE, dd, aa);
        bus_op(1'b1, 1'b1, 16'hFFFD, 8'h03, dd, aa);
        bus_op(1'b0, 1'b1, 16'hFFFD, 8'h00, dd, aa);
        check("shrink_chip1_cleared", 32'(dd), 0);
        check("shrink_chip1_act", 32'(aa), 1);

        // reset in the middle of a read
        @(negedge clk28);
        bus_if.a_reg = 16'hFFFD;
        bus_if.ioreq = 1'b1;
        bus_if.rd    = 1'b1;
        @(negedge clk28);
        @(negedge clk28);
        check("mid_read_act_before", 32'(d_out_active), 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_read_rst_act", 32'(d_out_active), 0);
        check("mid_read_rst_dout", 32'(d_out), 0);
        check("mid_read_rst_sel", 32'(dut.sel_q), 0);
        check("mid_read_rst_left", 32'(left), 0);
        bus_if.ioreq = 1'b0;
        bus_if.rd    = 1'b0;
        @(negedge clk28);
        #3 rst_n = 1'b1;

        // select chip1 again, then reset in the middle of a #BFFD write
        bus_op(1'b1, 1'b1, 16'hFFFD, 8'hFE, dd, aa);
        check("pre_rst_sel", 32'(dut.sel_q), 1);
        @(negedge clk28);
        bus_if.a_reg = 16'hBFFD;
        bus_if.d_reg = 8'h77;
        bus_if.ioreq = 1'b1;
        bus_if.wr    = 1'b1;
        @(negedge clk28);
        #2 rst_n = 1'b0;
        #1;
        check("mid_write_rst_sel", 32'(dut.sel_q), 0);
        check("mid_write_rst_left", 32'(left), 0);
        check("mid_write_rst_right", 32'(right), 0);
        check("mid_write_rst_act", 32'(d_out_active), 0);
        bus_if.ioreq = 1'b0;
        bus_if.wr    = 1'b0;
        @(negedge clk28);
        #3 rst_n = 1'b1;

        bus_op(1'b1, 1'b1, 16'hFFFD, 8'h08, dd, aa);
        bus_op(1'b0, 1'b1, 16'hFFFD, 8'h00, dd, aa);
        check("post_rst_r8_cleared", 32'(dd), 0);
        bus_op(1'b1, 1'b1, 16'hBFFD, 8'h1F, dd, aa);
        bus_op(1'b0, 1'b1, 16'hFFFD, 8'h00, dd, aa);
        check("post_rst_write_dout", 32'(dd), 32'h1F);
        check("post_rst_write_act", 32'(aa), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
